// File: rtl/map_query_arbiter_if.sv
// Bundle of requester-side and lookup-side signals for map_query_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the map lookup.
interface map_query_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*11-1:0] req_x;
    logic [NUM_REQ*10-1:0] req_y;
    logic [NUM_REQ-1:0]    ack;
    logic [1:0]            rsp_class;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  lk_valid;
    logic [10:0]           lk_x;
    logic [9:0]            lk_y;
    logic                  lk_ready;
    logic                  lk_rvalid;
    logic [1:0]            lk_class;
    logic                  timeout_err;

    modport slave (
        input  req, req_x, req_y, lk_ready, lk_rvalid, lk_class,
        output ack, rsp_class, grant_id, busy, lk_valid, lk_x, lk_y, timeout_err
    );

    modport master (
        output req, req_x, req_y, lk_ready, lk_rvalid, lk_class,
        input  ack, rsp_class, grant_id, busy, lk_valid, lk_x, lk_y, timeout_err
    );
endinterface

// File: rtl/map_query_arbiter.sv
// map_query_arbiter: round-robin sharing of one map obstacle-lookup port.
// Requests whose coordinates fall outside the 767x766 play field are
// answered locally with BOUNDARY (3).
// Optional watchdog: define MAP_ARB_TIMEOUT_EN to force a BOUNDARY answer
// plus timeout_err after TIMEOUT cycles in ISSUE/WAIT.
module map_query_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst,
    map_query_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] CLS_BOUNDARY = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  class_q, class_d;
    logic [10:0] cx_q, cx_d;
    logic [9:0]  cy_q, cy_d;
    logic        timeout_hit;

    // Requester inputs padded to 4 entries so a 2-bit index is always legal.
    logic [3:0]  req_pad;
    logic [10:0] x_arr [4];
    logic [9:0]  y_arr [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        if (g < NUM_REQ) begin : g_used
            assign req_pad[g] = bus.req[g];
            assign x_arr[g]   = bus.req_x[11*g +: 11];
            assign y_arr[g]   = bus.req_y[10*g +: 10];
        end else begin : g_pad
            assign req_pad[g] = 1'b0;
            assign x_arr[g]   = '0;
            assign y_arr[g]   = '0;
        end
    end

    // Round-robin pick: first set req searching upward from ptr+1, wrapping.
    logic       found;
    logic [1:0] sel;
    logic [2:0] cand;
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
            if (!found && req_pad[cand[1:0]]) begin
                found = 1'b1;
                sel   = cand[1:0];
            end
        end
    end

`ifdef MAP_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    assign timeout_hit = (state_q == ISSUE || state_q == WAIT) && (cnt_q == 8'(TIMEOUT));

    // Watchdog counter. Every ISSUE is entered from IDLE, so clearing in IDLE
    // gives a zero count on ISSUE entry. to_q records a forced answer; a real
    // response in the deadline cycle takes precedence.
    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        case (state_q)
            IDLE:        begin cnt_d = '0; to_d = 1'b0; end
            ISSUE, WAIT: begin
                cnt_d = cnt_q + 8'd1;
                to_d  = timeout_hit && !(state_q == WAIT && bus.lk_rvalid);
            end
            default:     ;
        endcase
    end

    // Watchdog state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign bus.timeout_err = (state_q == RESP) && to_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Next-state logic for the arbiter FSM and its latched transaction fields.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        class_d = class_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = sel;
                    cx_d    = x_arr[sel];
                    cy_d    = y_arr[sel];
                    if (x_arr[sel] > 11'd766 || y_arr[sel] > 10'd765) begin
                        class_d = CLS_BOUNDARY;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (timeout_hit) begin
                    class_d = CLS_BOUNDARY;
                    state_d = RESP;
                end else if (bus.lk_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.lk_rvalid) begin
                    class_d = bus.lk_class;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    class_d = CLS_BOUNDARY;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and transaction registers. Reset drops any in-flight lookup.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'(NUM_REQ - 1);
            grant_q <= '0;
            class_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            class_q <= class_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    // All outputs come from registers or decode of the state register only.
    assign bus.ack       = (state_q == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign bus.rsp_class = class_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.lk_valid  = (state_q == ISSUE);
    assign bus.lk_x      = cx_q;
    assign bus.lk_y      = cy_q;
endmodule

// File: tb/tb_map_query_arbiter.sv
// Self-checking bench for map_query_arbiter: a vector table of single
// transactions plus hand sequences for rotation, watchdog and mid-WAIT reset.
module tb_map_query_arbiter;
    localparam int NR = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    map_query_arbiter_if #(.NUM_REQ(NR)) bus();
    map_query_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int         id;
        logic [1:0] cls;
        bit         err;
    } exp_t;

    typedef struct {
        int          id;
        logic [10:0] x;
        logic [9:0]  y;
        int          rd;
        int          vd;
        logic [1:0]  cls;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[7];
    int   checks   = 0;
    int   errors   = 0;
    int   ack_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each ack pops the oldest expected answer.
    always @(negedge clk) begin
        if (rst && bus.ack != '0) begin
            ack_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_onehot", 32'(bus.ack), 32'(1 << mon_e.id));
                chk("grant_id", 32'(bus.grant_id), 32'(mon_e.id));
                chk("rsp_class", 32'(bus.rsp_class), 32'(mon_e.cls));
                chk("timeout_err", 32'(bus.timeout_err), 32'(mon_e.err));
            end
        end
    end

    // One isolated request with a scripted lookup response.
    task automatic txn(input int id, input logic [10:0] x, input logic [9:0] y,
                       input int rd, input int vd, input logic [1:0] cls, input bit to);
        bit   oof;
        int   exp_lat;
        int   got;
        int   vcnt;
        exp_t e;
        oof     = (x > 11'd766) || (y > 10'd765);
        exp_lat = oof ? 1 : (to ? TO + 2 : 3 + rd + vd);
        e.id    = id;
        e.cls   = (oof || to) ? 2'd3 : cls;
        e.err   = to && !oof;
        sb.push_back(e);
        bus.req                = '0;
        bus.req[id]            = 1'b1;
        bus.req_x[11*id +: 11] = x;
        bus.req_y[10*id +: 10] = y;
        got  = -1;
        vcnt = 0;
        for (int c = 0; c < 60 && got < 0; c++) begin
            bus.lk_ready  = (c == 1 + rd);
            bus.lk_rvalid = !to && (c == 2 + rd + vd);
            bus.lk_class  = cls;
            @(negedge clk);
            if (bus.lk_valid) begin
                vcnt++;
                chk("lk_x_stable", 32'(bus.lk_x), 32'(x));
                chk("lk_y_stable", 32'(bus.lk_y), 32'(y));
            end
            if (bus.ack != '0) got = c;
            @(posedge clk); #1;
        end
        bus.req       = '0;
        bus.lk_ready  = 1'b0;
        bus.lk_rvalid = 1'b0;
        chk("ack_latency", 32'(got), 32'(exp_lat));
        chk("lk_valid_cycles", 32'(vcnt), 32'(oof ? 0 : rd + 1));
        if (got < 0) begin
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            sb.delete();
        end
    endtask

    // Wait (bounded) until the ack counter reaches a target; lands in the IDLE cycle after it.
    task automatic wait_acks(input int target, input string name);
        int n;
        n = 0;
        while (ack_seen < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(ack_seen), 32'(target));
    endtask

    initial begin
        exp_t e;
        int   base;

        tbl[0] = '{0, 11'd100, 10'd230, 0, 0, 2'd1};
        tbl[1] = '{1, 11'd800, 10'd50,  0, 0, 2'd0};
        tbl[2] = '{2, 11'd766, 10'd765, 0, 1, 2'd2};
        tbl[3] = '{1, 11'd767, 10'd0,   0, 0, 2'd1};
        tbl[4] = '{2, 11'd0,   10'd766, 0, 0, 2'd1};
        tbl[5] = '{1, 11'd5,   10'd5,   5, 0, 2'd3};
        tbl[6] = '{0, 11'd300, 10'd400, 2, 3, 2'd0};

        // Reset with all requesters already pending.
        bus.req       = '1;
        bus.req_x     = {11'd30, 11'd20, 11'd10};
        bus.req_y     = {10'd33, 10'd22, 10'd11};
        bus.lk_ready  = 1'b1;
        bus.lk_rvalid = 1'b1;
        bus.lk_class  = 2'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_lk_valid", 32'(bus.lk_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_rsp_class", 32'(bus.rsp_class), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_lk_xy", 32'({bus.lk_x, bus.lk_y}), 32'd0);
        @(posedge clk); #1;

        // Continuous requests: strict rotation 0,1,2,0.
        foreach (tbl[i]) if (i < 4) begin
            e.id = (i == 3) ? 0 : i; e.cls = 2'd2; e.err = 1'b0;
            sb.push_back(e);
        end
        rst = 1'b1;
        wait_acks(4, "rotation_ack_count");
        bus.req       = '0;
        bus.lk_ready  = 1'b0;
        bus.lk_rvalid = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        @(posedge clk); #1;

        // Vector table: basic lookups, field edges, backpressure, class passthrough.
        for (int i = 0; i < 7; i++)
            txn(tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].rd, tbl[i].vd, tbl[i].cls, 1'b0);

`ifdef MAP_ARB_TIMEOUT_EN
        txn(1, 11'd10, 10'd10, 0, 0, 2'd1, 1'b1);
`endif

        // Stale response while idle must not produce an ack.
        base = ack_seen;
        bus.lk_rvalid = 1'b1;
        bus.lk_class  = 2'd1;
        @(posedge clk); #1;
        bus.lk_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stale_rvalid_no_ack", 32'(ack_seen), 32'(base));

        // Reset while waiting for the lookup result: transaction dropped.
        base = ack_seen;
        bus.req          = 3'b001;
        bus.req_x[10:0]  = 11'd50;
        bus.req_y[9:0]   = 10'd60;
        @(posedge clk); #1;
        bus.lk_ready = 1'b1;
        @(posedge clk); #1;
        bus.lk_ready = 1'b0;
        @(negedge clk);
        chk("midwait_busy", 32'(bus.busy), 32'd1);
        chk("midwait_lk_valid", 32'(bus.lk_valid), 32'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.lk_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.lk_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midwait_no_ack", 32'(ack_seen), 32'(base));
        chk("midwait_idle", 32'(bus.busy), 32'd0);

        // After reset requester 0 wins first even though it was served last.
        e.id = 0; e.cls = 2'd2; e.err = 1'b0;
        sb.push_back(e);
        bus.req       = '1;
        bus.req_x     = {11'd30, 11'd20, 11'd10};
        bus.req_y     = {10'd33, 10'd22, 10'd11};
        bus.lk_ready  = 1'b1;
        bus.lk_rvalid = 1'b1;
        bus.lk_class  = 2'd2;
        wait_acks(base + 1, "post_reset_first_grant");
        bus.req       = '0;
        bus.lk_ready  = 1'b0;
        bus.lk_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
